// File: rtl/vgacon_term_ctrl_if.sv
// Character-stream handshake, text-buffer write/read port and cursor status
// of the VGA console terminal sequencer.
interface vgacon_term_ctrl_if #(
    parameter int ADDR_W = 5
) ();
    logic              in_valid;
    logic [6:0]        in_char;
    logic [1:0]        in_color;
    logic              in_ready;
    logic              clear_req;
    logic              buf_wr_en;
    logic [ADDR_W-1:0] buf_wr_addr;
    logic [8:0]        buf_wr_data;
    logic [ADDR_W-1:0] buf_rd_addr;
    logic [8:0]        buf_rd_data;
    logic [1:0]        cursor_row;
    logic [3:0]        cursor_col;
    logic              busy;

    modport master (
        output in_valid, in_char, in_color, clear_req, buf_rd_data,
        input  in_ready, buf_wr_en, buf_wr_addr, buf_wr_data, buf_rd_addr,
               cursor_row, cursor_col, busy
    );

    modport slave (
        input  in_valid, in_char, in_color, clear_req, buf_rd_data,
        output in_ready, buf_wr_en, buf_wr_addr, buf_wr_data, buf_rd_addr,
               cursor_row, cursor_col, busy
    );
endinterface

// File: rtl/vgacon_term_ctrl.sv
// Terminal write sequencer: turns a character stream into text-buffer writes
// at a hardware cursor, with wrap, scroll-up by row copy and clear-screen.
module vgacon_term_ctrl #(
    parameter int NUM_ROWS       = 3,
    parameter int NUM_COLS       = 10,
    parameter int ADDR_W         = 5,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                rst,
    vgacon_term_ctrl_if.slave   bus
);
    localparam int N_CELLS  = NUM_ROWS * NUM_COLS;
    localparam int SCROLL_N = NUM_COLS * (NUM_ROWS - 1);
    localparam int LAST_ROW = (NUM_ROWS - 1) * NUM_COLS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCROLL,
        S_CLR_LINE,
        S_CLR_ALL
    } state_t;

    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLR_ALL : S_IDLE;
    localparam logic [8:0] SPACE = 9'h020;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [1:0]        row_q, row_d;
    logic [3:0]        col_q, col_d;
    logic              pend_q, pend_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [8:0]        wr_data_q, wr_data_d;

    logic              in_ready_c;
    logic              accept;
    logic              newline;
    logic [ADDR_W-1:0] cell_addr;

    assign in_ready_c = (state_q == S_IDLE) & ~bus.clear_req & ~pend_q;
    assign accept     = bus.in_valid & in_ready_c;
    assign cell_addr  = ADDR_W'(row_q) * ADDR_W'(NUM_COLS) + ADDR_W'(col_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        row_d     = row_q;
        col_d     = col_q;
        pend_d    = pend_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        newline   = 1'b0;

        // A clear arriving mid-operation is remembered and replayed at the end.
        if (state_q != S_IDLE && bus.clear_req) begin
            pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.clear_req) begin
                    state_d = S_CLR_ALL;
                    cnt_d   = '0;
                end else if (accept) begin
                    case (bus.in_char)
                        7'h0D: col_d = '0;
                        7'h0A: newline = 1'b1;
                        7'h08: begin
                            if (col_q != 4'd0) col_d = col_q - 4'd1;
                        end
                        7'h0C: begin
                            state_d = S_CLR_ALL;
                            cnt_d   = '0;
                        end
                        default: begin
                            if (bus.in_char >= 7'h20 && bus.in_char <= 7'h7E) begin
                                wr_en_d   = 1'b1;
                                wr_addr_d = cell_addr;
                                wr_data_d = {bus.in_color, bus.in_char};
                                if (col_q == 4'(NUM_COLS - 1)) begin
                                    col_d   = '0;
                                    newline = 1'b1;
                                end else begin
                                    col_d = col_q + 4'd1;
                                end
                            end
                        end
                    endcase
                    if (newline) begin
                        if (row_q < 2'(NUM_ROWS - 1)) begin
                            row_d = row_q + 2'd1;
                        end else begin
                            state_d = S_SCROLL;
                            cnt_d   = '0;
                        end
                    end
                end
            end

            S_SCROLL: begin
                // Data read this cycle from row below lands one row up next cycle.
                wr_en_d   = 1'b1;
                wr_addr_d = cnt_q;
                wr_data_d = bus.buf_rd_data;
                if (cnt_q == ADDR_W'(SCROLL_N - 1)) begin
                    state_d = S_CLR_LINE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_CLR_LINE: begin
                wr_en_d   = 1'b1;
                wr_addr_d = ADDR_W'(LAST_ROW) + cnt_q;
                wr_data_d = SPACE;
                if (cnt_q == ADDR_W'(NUM_COLS - 1)) begin
                    cnt_d = '0;
                    if (pend_q | bus.clear_req) begin
                        state_d = S_CLR_ALL;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_CLR_ALL: begin
                wr_en_d   = 1'b1;
                wr_addr_d = cnt_q;
                wr_data_d = SPACE;
                if (cnt_q == ADDR_W'(N_CELLS - 1)) begin
                    cnt_d = '0;
                    row_d = '0;
                    col_d = '0;
                    if (pend_q | bus.clear_req) begin
                        state_d = S_CLR_ALL;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RST_STATE;
            cnt_q     <= '0;
            row_q     <= '0;
            col_q     <= '0;
            pend_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            row_q     <= row_d;
            col_q     <= col_d;
            pend_q    <= pend_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.buf_wr_en   = wr_en_q;
    assign bus.buf_wr_addr = wr_addr_q;
    assign bus.buf_wr_data = wr_data_q;
    assign bus.buf_rd_addr = (state_q == S_SCROLL) ? cnt_q + ADDR_W'(NUM_COLS) : '0;
    assign bus.cursor_row  = row_q;
    assign bus.cursor_col  = col_q;
    assign bus.busy        = (state_q != S_IDLE);
endmodule

// File: tb/tb_vgacon_term_ctrl.sv
// Scoreboard bench for vgacon_term_ctrl: a screen-level model predicts every
// buffer write and the cursor; a forked monitor pops and compares writes.
module tb_vgacon_term_ctrl;
    localparam int NR    = 3;
    localparam int NC    = 10;
    localparam int AW    = 5;
    localparam int NCELL = NR * NC;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vgacon_term_ctrl_if #(.ADDR_W(AW)) bus ();

    vgacon_term_ctrl #(
        .NUM_ROWS(NR), .NUM_COLS(NC), .ADDR_W(AW), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Text buffer RAM owned by the environment.
    logic [8:0] ram [0:31];
    always @(posedge clk) begin
        if (bus.buf_wr_en) ram[bus.buf_wr_addr] <= bus.buf_wr_data;
    end
    assign bus.buf_rd_data = ram[bus.buf_rd_addr];

    // Screen-level reference model.
    logic [8:0]  screen [0:NCELL-1];
    int          mrow, mcol;
    logic [13:0] expq [$];
    int          total, bad;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_print(input logic [6:0] c);
        return (c >= 7'h20) && (c <= 7'h7E);
    endfunction

    function automatic void push_wr(input int addr, input logic [8:0] data);
        logic [4:0] a;
        a = 5'(addr);
        expq.push_back({a, data});
    endfunction

    function automatic void model_clear_all();
        for (int i = 0; i < NCELL; i++) begin
            screen[i] = 9'h020;
            push_wr(i, 9'h020);
        end
        mrow = 0;
        mcol = 0;
    endfunction

    function automatic void model_scroll();
        for (int i = 0; i < NCELL - NC; i++) begin
            screen[i] = screen[i + NC];
            push_wr(i, screen[i]);
        end
        for (int j = NCELL - NC; j < NCELL; j++) begin
            screen[j] = 9'h020;
            push_wr(j, 9'h020);
        end
    endfunction

    function automatic void model_newline();
        if (mrow < NR - 1) mrow++;
        else model_scroll();
    endfunction

    function automatic void model_char(input logic [6:0] c, input logic [1:0] color);
        int idx;
        case (c)
            7'h0D: mcol = 0;
            7'h0A: model_newline();
            7'h08: if (mcol > 0) mcol--;
            7'h0C: model_clear_all();
            default: begin
                if (is_print(c)) begin
                    idx = mrow * NC + mcol;
                    screen[idx] = {color, c};
                    push_wr(idx, {color, c});
                    if (mcol == NC - 1) begin
                        mcol = 0;
                        model_newline();
                    end else begin
                        mcol++;
                    end
                end
            end
        endcase
    endfunction

    task automatic monitor();
        logic [13:0] e;
        forever begin
            @(negedge clk);
            if (bus.buf_wr_en) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got addr %0d data %0h expected no write at %0t",
                             bus.buf_wr_addr, bus.buf_wr_data, $time);
                end else begin
                    e = expq.pop_front();
                    check("wr_addr", int'(bus.buf_wr_addr), int'(e[13:9]));
                    check("wr_data", int'(bus.buf_wr_data), int'(e[8:0]));
                end
            end
        end
    endtask

    task automatic send(input logic [6:0] c, input logic [1:0] color, input bit chk_ready);
        int w;
        w = 0;
        @(negedge clk);
        if (chk_ready) check("ready_now", int'(bus.in_ready), 1);
        while (!bus.in_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!bus.in_ready) begin
            check("ready_timeout", 0, 1);
            return;
        end
        bus.in_valid = 1'b1;
        bus.in_char  = c;
        bus.in_color = color;
        model_char(c, color);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("wr_after_hs", int'(bus.buf_wr_en), int'(is_print(c)));
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (bus.busy && w < 500) begin
            @(negedge clk);
            w++;
        end
        check("idle_reached", int'(bus.busy), 0);
    endtask

    task automatic check_cursor(input string tag);
        check({tag, "_row"}, int'(bus.cursor_row), mrow);
        check({tag, "_col"}, int'(bus.cursor_col), mcol);
    endtask

    function automatic logic [6:0] rand_print();
        return 7'($urandom_range(32'h20, 32'h7E));
    endfunction

    initial begin
        int busy_cnt, nready_cnt, r;
        logic [6:0] c;
        total = 0;
        bad   = 0;
        mrow  = 0;
        mcol  = 0;
        bus.in_valid  = 1'b0;
        bus.in_char   = '0;
        bus.in_color  = '0;
        bus.clear_req = 1'b0;
        rst = 1'b1;
        fork
            monitor();
        join_none

        // Reset releases into a full clear of 30 cells.
        repeat (3) @(negedge clk);
        model_clear_all();
        rst = 1'b0;
        wait_idle();
        #1;
        check("post_reset_ready", int'(bus.in_ready), 1);
        check("post_reset_row", int'(bus.cursor_row), 0);
        check("post_reset_col", int'(bus.cursor_col), 0);

        // Single printable with color 2.
        send(7'h41, 2'd2, 1'b1);
        check("a_addr", int'(bus.buf_wr_addr), 0);
        check("a_data", int'(bus.buf_wr_data), 9'h141);
        check("a_row", int'(bus.cursor_row), 0);
        check("a_col", int'(bus.cursor_col), 1);

        // Ten printables fill row 0 and wrap to (1,0).
        send(7'h0D, 2'd0, 1'b1);
        for (int i = 0; i < NC; i++) send(rand_print(), 2'($urandom_range(0, 3)), 1'b1);
        @(negedge clk);
        check("wrap_row", int'(bus.cursor_row), 1);
        check("wrap_col", int'(bus.cursor_col), 0);

        // Position at (2,4) and scroll with LF.
        send(7'h0D, 2'd0, 1'b0);
        while (mrow < NR - 1) send(7'h0A, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++) send(rand_print(), 2'($urandom_range(0, 3)), 1'b0);
        send(7'h0A, 2'd0, 1'b1);
        busy_cnt   = 0;
        nready_cnt = 0;
        while (bus.busy && busy_cnt < 200) begin
            busy_cnt++;
            if (!bus.in_ready) nready_cnt++;
            @(posedge clk);
            #1;
        end
        check("scroll_busy_cycles", busy_cnt, 30);
        check("scroll_notready_cycles", nready_cnt, 30);
        check("scroll_row", int'(bus.cursor_row), 2);
        check("scroll_col", int'(bus.cursor_col), 4);

        // clear_req pulsed twice mid-scroll collapses into one trailing clear.
        send(7'h0A, 2'd0, 1'b1);
        repeat (5) @(negedge clk);
        bus.clear_req = 1'b1;
        @(negedge clk);
        bus.clear_req = 1'b0;
        repeat (3) @(negedge clk);
        bus.clear_req = 1'b1;
        @(negedge clk);
        bus.clear_req = 1'b0;
        model_clear_all();
        wait_idle();
        check("midclr_row", int'(bus.cursor_row), 0);
        check("midclr_col", int'(bus.cursor_col), 0);

        // BS at column 0, CR and an ignored code: no writes, col stays 0.
        send(7'h08, 2'd0, 1'b1);
        send(7'h0D, 2'd0, 1'b1);
        send(7'h07, 2'd0, 1'b1);
        check("ctrl_col", int'(bus.cursor_col), 0);

        // clear_req in IDLE blocks a simultaneous character.
        send(7'h42, 2'd1, 1'b1);
        @(negedge clk);
        bus.clear_req = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_char   = 7'h5A;
        bus.in_color  = 2'd3;
        #1;
        check("clr_blocks_ready", int'(bus.in_ready), 0);
        @(negedge clk);
        bus.clear_req = 1'b0;
        bus.in_valid  = 1'b0;
        model_clear_all();
        wait_idle();
        check_cursor("idle_clr");

        // Randomized character stream.
        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      c = rand_print();
            else if (r < 78) c = 7'h0D;
            else if (r < 87) c = 7'h0A;
            else if (r < 93) c = 7'h08;
            else if (r < 97) c = 7'($urandom_range(0, 31) == 0 ? 32'h7F : 32'h1B);
            else             c = 7'h0C;
            send(c, 2'($urandom_range(0, 3)), 1'b0);
        end
        @(negedge clk);
        wait_idle();
        check_cursor("random_end");

        repeat (3) @(negedge clk);
        check("queue_empty", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vgacon_term_ctrl.md
Name: vgacon_term_ctrl

Overview:
- Terminal-style write sequencer for the VGA console text buffer (NUM_ROWS x NUM_COLS cells, 9-bit entries: {color[1:0], ascii[6:0]}).
- Accepts a character stream and turns it into buffer writes at a hardware cursor.
- Handles control codes, auto-wrap, scroll-up (row copy) and clear-screen.
- Sole owner of the buffer write port; uses one combinational buffer read port for scrolling.

Parameters:
- NUM_ROWS, 3, text rows.
- NUM_COLS, 10, text columns.
- ADDR_W, 5, buffer address width; must satisfy 2^ADDR_W >= NUM_ROWS*NUM_COLS.
- CLEAR_ON_RESET, 1, when 1 the block runs a full clear after reset is released.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  character offered
- in_char  in  7  ASCII code
- in_color  in  2  color index for a printable char, sampled at handshake
- in_ready  out  1  character accepted when in_valid & in_ready
- clear_req  in  1  one-cycle pulse: clear screen and home cursor
- buf_wr_en  out  1  buffer write strobe (registered)
- buf_wr_addr  out  ADDR_W  write address = row*NUM_COLS+col (registered)
- buf_wr_data  out  9  {color, ascii} (registered)
- buf_rd_addr  out  ADDR_W  scroll read address (combinational from state/counter)
- buf_rd_data  in  9  buffer contents at buf_rd_addr, same cycle
- cursor_row  out  2  current row
- cursor_col  out  4  current column
- busy  out  1  high when state != IDLE

Behaviour:
- States:
  - IDLE.
  - SCROLL: copy rows 1..NUM_ROWS-1 up by one row.
  - CLR_LINE: fill the last row with spaces.
  - CLR_ALL: fill all NUM_ROWS*NUM_COLS cells with spaces.
- Reset:
  - State becomes CLR_ALL if CLEAR_ON_RESET, else IDLE.
  - Cursor = (0,0); buf_wr_en=0, buf_wr_addr=0, buf_wr_data=0; clear-pending flag=0.
  - Reset mid-operation aborts it immediately; no further writes are issued for that operation.
  - Buffer contents are not reset by this block.
- in_ready = (state==IDLE) & ~clear_req & ~clear_pending.
- All writes appear on the buf_wr_* registers one cycle after the decision cycle. buf_wr_en is high for exactly one cycle per write.
- Accepted characters in IDLE:
  - Printable 0x20..0x7E: write {in_color, in_char} at the cursor, then col+1.
    - If col was NUM_COLS-1: col=0 and newline handling applies.
  - 0x0D CR: col=0, no write.
  - 0x0A LF: newline handling, col unchanged, no write.
  - 0x08 BS: col-1 if col>0, else no change; no write, no erase.
  - 0x0C FF: same as clear_req.
  - Any other code: consumed, no effect.
- Newline handling:
  - If row < NUM_ROWS-1: row+1, stay IDLE.
  - Else: row stays NUM_ROWS-1 and state goes to SCROLL.
- SCROLL:
  - Counter k runs 0..NUM_COLS*(NUM_ROWS-1)-1, one per cycle.
  - buf_rd_addr = k+NUM_COLS.
  - Next cycle: write buf_rd_data to address k.
  - After the last k, go to CLR_LINE.
  - buf_rd_addr = 0 outside SCROLL.
- CLR_LINE: NUM_COLS cycles writing 9'h020 to (NUM_ROWS-1)*NUM_COLS+j, j ascending; then IDLE.
- CLR_ALL:
  - NUM_ROWS*NUM_COLS cycles writing 9'h020 to ascending addresses 0..N-1.
  - Then cursor=(0,0), IDLE.
- Default timing: 30 cycles busy for CLR_ALL; 20+10 = 30 cycles for a scroll.
- clear_req handling:
  - clear_req in IDLE: go to CLR_ALL next cycle. Any in_valid in the same cycle is not accepted.
  - clear_req while busy sets clear_pending. When the current operation finishes, go directly to CLR_ALL (not IDLE); clear_pending clears on entry.
  - Repeated pulses while pending collapse to one clear.
- Write ordering: in the last cycle of an operation plus one, no write from the next operation overlaps. Writes are strictly one per cycle.

Test Plan:
- Reset with CLEAR_ON_RESET=1 -> 30 consecutive writes of 0x020 to addr 0..29; busy low and in_ready high on the following cycle; cursor (0,0).
- Send 'A' (0x41) color 2 at (0,0) -> one write addr 0 data 0x141 one cycle after handshake; cursor (0,1).
- Send 10 printables on row 0 -> writes addr 0..9; cursor wraps to (1,0) with no extra write.
- Cursor (2,4), send LF -> SCROLL reads 10..29, writes 0..19 with copied data, then 0x020 to 20..29; cursor (2,4); in_ready low for 30 cycles.
- clear_req pulsed mid-SCROLL -> scroll and line-clear complete, then a 30-cycle CLR_ALL follows; cursor (0,0).
- Send BS at col 0, CR, 0x07 -> no writes; cursor col stays 0; each character accepted in one cycle.
